// File: rtl/tw_pkg.sv
// Shared types and constants for the stage-0 twiddle horizontal loader.
// The GAP state exists only when TW_LOADER_GAP_EN is defined.
package tw_pkg;

  typedef enum logic [2:0] {
    S_FILL = 3'd0,
    S_WAIT = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
`ifdef TW_LOADER_GAP_EN
    S_DONE = 3'd4,
    S_GAP  = 3'd5
`else
    S_DONE = 3'd4
`endif
  } tw_state_e;

  localparam logic [1:0] ROM4_W_IDLE = 2'd0;
  localparam logic [1:0] ROM4_W_HI   = 2'd1;
  localparam logic [1:0] ROM4_W_LO   = 2'd2;

  localparam int unsigned TW_BURST_LEN = 4;

endpackage

// File: rtl/tw_entry_buf.sv
// Four-entry twiddle buffer with one write port and upper/lower half read ports.
module tw_entry_buf
  import tw_pkg::*;
#(
  parameter int unsigned P_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [1:0]           wr_idx,
  input  logic [P_WIDTH-1:0]   wdata,
  input  logic [1:0]           rd_idx,
  output logic [P_WIDTH/2-1:0] rd_hi,
  output logic [P_WIDTH/2-1:0] rd_lo
);

  logic [P_WIDTH-1:0] mem [TW_BURST_LEN];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TW_BURST_LEN; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_idx] <= wdata;
    end
  end

  assign rd_hi = mem[rd_idx][P_WIDTH-1 -: P_WIDTH/2];
  assign rd_lo = mem[rd_idx][P_WIDTH/2-1:0];

endmodule

// File: rtl/tw_horizontal_loader.sv
// Buffers four twiddle entries and bursts them into the stage-0 ROM as upper
// halves then lower halves. TW_LOADER_GAP_EN inserts one idle cycle between phases.
module tw_horizontal_loader
  import tw_pkg::*;
#(
  parameter int unsigned P_WIDTH         = 128,
  parameter int unsigned horizontal_DW   = 64,
  parameter int unsigned init_store_data = 4
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic [P_WIDTH-1:0]       tf_in,
  input  logic                     tf_valid,
  output logic                     tf_ready,
  input  logic                     rom_idle,
  output logic [horizontal_DW-1:0] horizontal_tf_out,
  output logic [1:0]               ROM4_w,
  output logic                     busy,
  output logic                     load_done
);

  localparam logic [1:0] LAST_IDX = 2'(init_store_data - 1);

  tw_state_e        state;
  logic [1:0]       wr_idx;
  logic [1:0]       rd_idx;
  logic             buf_we;
  logic [P_WIDTH/2-1:0] rd_hi;
  logic [P_WIDTH/2-1:0] rd_lo;

  assign buf_we = (state == S_FILL) && tf_valid;

  tw_entry_buf #(.P_WIDTH(P_WIDTH)) u_buf (
    .clk    (CLK),
    .rst_n  (rst_n),
    .we     (buf_we),
    .wr_idx (wr_idx),
    .wdata  (tf_in),
    .rd_idx (rd_idx),
    .rd_hi  (rd_hi),
    .rd_lo  (rd_lo)
  );

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state  <= S_FILL;
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (tf_valid) begin
            wr_idx <= wr_idx + 2'd1;
            if (wr_idx == LAST_IDX) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rom_idle) begin
            state  <= S_HI;
            rd_idx <= '0;
          end
        end
        S_HI: begin
          rd_idx <= rd_idx + 2'd1;
`ifdef TW_LOADER_GAP_EN
          if (rd_idx == LAST_IDX) state <= S_GAP;
`else
          if (rd_idx == LAST_IDX) state <= S_LO;
`endif
        end
`ifdef TW_LOADER_GAP_EN
        S_GAP: state <= S_LO;
`endif
        S_LO: begin
          rd_idx <= rd_idx + 2'd1;
          if (rd_idx == LAST_IDX) state <= S_DONE;
        end
        S_DONE:  state <= S_FILL;
        default: state <= S_FILL;
      endcase
    end
  end

  // Outputs decode only from registered state/indices/buffer, so rom_idle and
  // tf_valid never reach an output combinationally.
  always_comb begin
    ROM4_w            = ROM4_W_IDLE;
    horizontal_tf_out = '0;
    if (state == S_HI) begin
      ROM4_w            = ROM4_W_HI;
      horizontal_tf_out = rd_hi;
    end else if (state == S_LO) begin
      ROM4_w            = ROM4_W_LO;
      horizontal_tf_out = rd_lo;
    end
  end

  assign tf_ready  = (state == S_FILL);
  assign busy      = (state != S_FILL);
  assign load_done = (state == S_DONE);

endmodule

// File: tb/tb_tw_horizontal_loader.sv
// Scoreboard bench for tw_horizontal_loader; honours TW_LOADER_GAP_EN when defined.
module tb_tw_horizontal_loader;

`ifdef TW_LOADER_GAP_EN
  localparam int GAP_CYC = 1;
`else
  localparam int GAP_CYC = 0;
`endif
  localparam int DONE_LAT = 9 + GAP_CYC;

  logic         CLK = 1'b0;
  logic         rst_n;
  logic [127:0] tf_in;
  logic         tf_valid;
  logic         tf_ready;
  logic         rom_idle;
  logic [63:0]  horizontal_tf_out;
  logic [1:0]   ROM4_w;
  logic         busy;
  logic         load_done;

  always #5 CLK = ~CLK;

  tw_horizontal_loader #(
    .P_WIDTH(128),
    .horizontal_DW(64),
    .init_store_data(4)
  ) dut (
    .CLK               (CLK),
    .rst_n             (rst_n),
    .tf_in             (tf_in),
    .tf_valid          (tf_valid),
    .tf_ready          (tf_ready),
    .rom_idle          (rom_idle),
    .horizontal_tf_out (horizontal_tf_out),
    .ROM4_w            (ROM4_w),
    .busy              (busy),
    .load_done         (load_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ROM model: 2-bit horizontal counter, cleared whenever ROM4_w is 0
  logic [1:0]   rom_cnt = 2'd0;
  logic [127:0] rom_mem [4];
  always @(posedge CLK) begin
    if (ROM4_w == 2'd1) rom_mem[rom_cnt][127:64] <= horizontal_tf_out;
    else if (ROM4_w == 2'd2) rom_mem[rom_cnt][63:0] <= horizontal_tf_out;
    rom_cnt <= (ROM4_w != 2'd0) ? rom_cnt + 2'd1 : 2'd0;
  end

  // Scoreboard: code 1/2 = ROM write, code 3 = load_done pulse
  typedef struct packed {
    logic [1:0]  w;
    logic [63:0] d;
  } exp_t;
  exp_t q[$];

  logic         mon_en = 1'b0;
  logic [1:0]   code;
  logic [1:0]   prev_nz = 2'd0;
  int           zeros = 0;
  exp_t         e;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (ROM4_w != 2'd0) begin
        if (prev_nz == 2'd1 && ROM4_w == 2'd2) chk("gap_cycles", 128'(zeros), 128'(GAP_CYC));
        prev_nz = ROM4_w;
        zeros   = 0;
      end else begin
        zeros++;
      end
      code = load_done ? 2'd3 : ROM4_w;
      if (code != 2'd0) begin
        if (q.size() == 0) begin
          chk("unexpected_event", 128'(code), 128'd0);
        end else begin
          e = q.pop_front();
          chk("ev_code", 128'(code), 128'(e.w));
          if (e.w != 2'd3) chk("ev_data", 128'(horizontal_tf_out), 128'(e.d));
        end
      end
    end
  end

  logic [127:0] cur [4];

  task automatic load_set(input logic [7:0] hb, input logic [7:0] lb);
    logic [7:0] h, l;
    for (int i = 0; i < 4; i++) begin
      h = hb + 8'(i);
      l = lb + 8'(i);
      cur[i] = {{8{h}}, {8{l}}};
    end
  endtask

  task automatic push_expect(input int nlo, input bit done);
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      x.w = 2'd1; x.d = cur[i][127:64]; q.push_back(x);
    end
    for (int i = 0; i < nlo; i++) begin
      x.w = 2'd2; x.d = cur[i][63:0]; q.push_back(x);
    end
    if (done) begin
      x.w = 2'd3; x.d = 64'd0; q.push_back(x);
    end
  endtask

  task automatic send_all();
    for (int i = 0; i < 4; i++) begin
      tf_in    = cur[i];
      tf_valid = 1'b1;
      @(posedge CLK); #1;
    end
    tf_valid = 1'b0;
    tf_in    = '0;
  endtask

  task automatic wait_done(output int cyc);
    bit seen;
    seen = 0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      if (load_done) seen = 1;
    end
    chk("load_done_seen", 128'(load_done), 128'd1);
    @(posedge CLK); #1;
    chk("ready_after_done", 128'(tf_ready), 128'd1);
  endtask

  task automatic check_rom();
    for (int i = 0; i < 4; i++) chk("rom_entry", rom_mem[i], cur[i]);
  endtask

  initial begin
    int cyc, viol, cnt, acc, k;
    bit wait_chk;

    rst_n    = 1'b0;
    tf_in    = '0;
    tf_valid = 1'b0;
    rom_idle = 1'b0;
    repeat (2) @(posedge CLK);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    chk("rst_tf_ready", 128'(tf_ready), 128'd1);
    chk("rst_rom4_w", 128'(ROM4_w), 128'd0);
    chk("rst_tf_out", 128'(horizontal_tf_out), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_load_done", 128'(load_done), 128'd0);

    // basic load with ROM idle
    rom_idle = 1'b1;
    load_set(8'hA0, 8'hB0);
    push_expect(4, 1);
    send_all();
    chk("basic_wait_busy", 128'(busy), 128'd1);
    chk("basic_wait_ready", 128'(tf_ready), 128'd0);
    wait_done(cyc);
    chk("basic_latency", 128'(cyc), 128'(DONE_LAT));
    check_rom();

    // backpressure: ROM busy for 20 cycles
    rom_idle = 1'b0;
    load_set(8'hC0, 8'hD0);
    push_expect(4, 1);
    send_all();
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (!busy || tf_ready || ROM4_w != 2'd0) viol++;
    end
    chk("backpressure_hold", 128'(viol), 128'd0);
    rom_idle = 1'b1;
    @(posedge CLK); #1;
    chk("burst_start", 128'(ROM4_w), 128'd1);
    wait_done(cyc);
    chk("bp_latency", 128'(cyc), 128'(DONE_LAT - 1));
    check_rom();

    // rom_idle dropped after the 2nd HI cycle
    load_set(8'h10, 8'h20);
    push_expect(4, 1);
    send_all();
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      @(posedge CLK); #1;
      if (ROM4_w == 2'd1) cnt++;
    end
    rom_idle = 1'b0;
    chk("drop_hi_seen", 128'(cnt), 128'd2);
    wait_done(cyc);
    check_rom();

    // reset during the 2nd LO cycle
    rom_idle = 1'b1;
    load_set(8'h30, 8'h40);
    push_expect(2, 0);
    send_all();
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      @(posedge CLK); #1;
      if (ROM4_w == 2'd2) cnt++;
    end
    rst_n = 1'b0;
    @(posedge CLK); #1;
    chk("midrst_rom4_w", 128'(ROM4_w), 128'd0);
    chk("midrst_tf_out", 128'(horizontal_tf_out), 128'd0);
    chk("midrst_ready", 128'(tf_ready), 128'd1);
    chk("midrst_queue", 128'(q.size()), 128'd0);
    rst_n = 1'b1;
    load_set(8'h50, 8'h60);
    push_expect(4, 1);
    send_all();
    wait_done(cyc);
    check_rom();

    // gapped valid stream; extra valid during WAIT must be ignored
    rom_idle = 1'b0;
    load_set(8'h70, 8'h80);
    acc = 0;
    k = 0;
    wait_chk = 0;
    for (int c = 0; c < 10; c++) begin
      tf_valid = (c % 2 == 0);
      tf_in    = (k < 4) ? cur[k] : {4{32'hDEADBEEF}};
      if (tf_valid && tf_ready) begin
        acc++;
        k++;
      end
      @(posedge CLK); #1;
      if (acc == 4 && !wait_chk) begin
        chk("wait_after_4th", 128'(busy), 128'd1);
        wait_chk = 1;
      end
    end
    tf_valid = 1'b0;
    chk("gapped_accepts", 128'(acc), 128'd4);
    push_expect(4, 1);
    rom_idle = 1'b1;
    wait_done(cyc);
    check_rom();

    repeat (3) @(posedge CLK);
    #1 chk("final_queue_empty", 128'(q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tw_horizontal_loader.md
# tw_horizontal_loader

Streams four 128-bit twiddle-factor entries into the stage-0 twiddle ROM over its 64-bit horizontal write port. Entries arrive from the host or twiddle generator on a valid/ready stream. The block buffers all four, waits until the ROM is idle, then issues an atomic burst: first the upper halves of entries 0..3 with `ROM4_w`=1, then the lower halves with `ROM4_w`=2. This matches the ROM's wrapping 2-bit horizontal counter, which advances on every cycle `ROM4_w` is non-zero and clears when `ROM4_w` is 0.

## Interface
Parameters:
- `P_WIDTH`, 128, width of one twiddle entry (high 64 = twiddle, low 64 = Shoup/const companion).
- `horizontal_DW`, 64, width of the horizontal write bus; must equal `P_WIDTH/2`.
- `init_store_data`, 4, entries per burst; fixed at 4 to match the ROM's 2-bit horizontal counter.

Ports:
- `CLK`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `tf_in`  in  `P_WIDTH`  incoming twiddle entry.
- `tf_valid`  in  1  `tf_in` is valid.
- `tf_ready`  out  1  block accepts an entry this cycle.
- `rom_idle`  in  1  ROM is not being read (its CEN is high); a burst may start.
- `horizontal_tf_out`  out  `horizontal_DW`  half-entry driven to the ROM's `horizontal_tf_in`.
- `ROM4_w`  out  2  0 = idle, 1 = write upper half, 2 = write lower half; 3 is never driven.
- `busy`  out  1  state is not FILL.
- `load_done`  out  1  one-cycle pulse after the last lower half is written.

## Operation
- FSM states: FILL, WAIT, HI, GAP (present only with the macro), LO, DONE.
- FILL:
  - `tf_ready`=1.
  - Each cycle with `tf_valid`&&`tf_ready` writes `tf_in` to `buf[wr_idx]`, then increments `wr_idx` (2 bits).
  - The accept that writes `wr_idx`=3 moves the FSM to WAIT and wraps `wr_idx` to 0.
- WAIT: `tf_ready`=0. When `rom_idle`=1, go to HI with `rd_idx`=0.
- HI:
  - `ROM4_w`=1, `horizontal_tf_out`=`buf[rd_idx][127:64]`, `rd_idx` increments each cycle.
  - After `rd_idx`=3, go to LO (or to GAP with the macro); `rd_idx` wraps to 0.
- GAP: `ROM4_w`=0 and `horizontal_tf_out`=0 for exactly one cycle, then LO.
- LO:
  - `ROM4_w`=2, `horizontal_tf_out`=`buf[rd_idx][63:0]`, `rd_idx` increments each cycle.
  - After `rd_idx`=3, go to DONE.
- DONE: `load_done`=1 for one cycle, then FILL. Buffer contents are kept; a new fill overwrites them.
- Outputs outside HI/LO: `ROM4_w`=0, `horizontal_tf_out`=0.
- All outputs decode from registered state, indices and buffer only. There is no combinational path from any input to any output.
- Bursts are atomic: `rom_idle` falling during HI/GAP/LO is ignored. `tf_valid` outside FILL is ignored, with no accept and no overwrite.

## Timing
- Reset (`rst_n`=0 at an edge) gives the following state after that edge:
  - FSM=FILL, `wr_idx`=`rd_idx`=0, all `buf` entries=0.
  - Outputs: `tf_ready`=1, `ROM4_w`=0, `horizontal_tf_out`=0, `busy`=0, `load_done`=0.
- Reset mid-burst: `ROM4_w` is 0 from the next cycle, which also clears the ROM's horizontal counter. The partial burst is abandoned and all four entries must be resent.
- Burst latency: WAIT with `rom_idle`=1 sampled at edge N. Without the macro:
  - `ROM4_w`=1 in cycles N+1..N+4.
  - `ROM4_w`=2 in cycles N+5..N+8.
  - `load_done` in N+9.
  - FILL and `tf_ready`=1 from N+10.
- With the macro, every event from LO onward shifts by +1 cycle: LO in N+6..N+9, `load_done` in N+10.
- Fill throughput: 1 entry per cycle. Four back-to-back accepts take 4 cycles, and WAIT is entered on the cycle after the 4th accept.
- `rom_idle` already high when WAIT is entered: HI starts on the next cycle (minimum 1 WAIT cycle).

## Configuration
- `TW_LOADER_GAP_EN` defined: GAP state is compiled in.
  - One `ROM4_w`=0 cycle between the HI and LO phases.
  - The ROM counter is explicitly re-zeroed before the lower halves, independent of its wrap behaviour.
- Undefined: HI runs directly into LO in 8 contiguous write cycles, relying on the ROM counter wrapping 3→0.

## Structure
- Shared package `tw_pkg`:
  - FSM state enum.
  - `ROM4_W_IDLE`=2'd0, `ROM4_W_HI`=2'd1, `ROM4_W_LO`=2'd2.
  - `TW_BURST_LEN`=4.
- One sub-module, `tw_entry_buf`: 4×`P_WIDTH` register file with write enable/index and two 64-bit read ports (upper and lower half at `rd_idx`). Synchronous clear on `rst_n`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles, release → `tf_ready`=1, `ROM4_w`=0, `horizontal_tf_out`=0, `busy`=0.
- Basic load:
  - Stimulus: send entries `128'hA0..A0_B0..B0` through `128'hA3.._B3..` back-to-back with `rom_idle`=1.
  - Required: `ROM4_w`=1 with `A0..`, `A1..`, `A2..`, `A3..` on 4 consecutive cycles.
  - Then `ROM4_w`=2 with `B0..`, `B1..`, `B2..`, `B3..`.
  - Then a single `load_done` pulse.
  - A ROM model's `buf_data_stage0[0..3]` matches the inputs.
- Backpressure: 4 entries sent with `rom_idle`=0 for 20 cycles → `busy`=1, `tf_ready`=0, `ROM4_w`=0 throughout. `rom_idle`=1 → burst begins next cycle.
- `rom_idle` dropped after the 2nd HI cycle → burst still completes all 8 writes unchanged.
- Reset at the 2nd LO cycle → `ROM4_w`=0 next cycle. A fresh 4-entry load completes correctly.
- Gapped stream: `tf_valid` toggling 1,0,1,0… → exactly 4 accepts, WAIT entered after the 4th. Extra valid during WAIT is not accepted. With `TW_LOADER_GAP_EN`, exactly one `ROM4_w`=0 cycle between the HI and LO phases.
